// File: rtl/chess_pkg.sv
// Shared chess constants: side encoding, rank masks, emitter state encoding and
// the single-rank pawn push helper.
package chess_pkg;

   localparam int unsigned BB_W      = 64;
   localparam int unsigned SQ_W_DEF  = 6;
   localparam int unsigned CNT_W_DEF = 5;

   localparam logic SIDE_WHITE = 1'b0;
   localparam logic SIDE_BLACK = 1'b1;

   localparam logic [BB_W-1:0] RANK_1 = 64'h00000000000000FF;
   localparam logic [BB_W-1:0] RANK_2 = 64'h000000000000FF00;
   localparam logic [BB_W-1:0] RANK_3 = 64'h0000000000FF0000;
   localparam logic [BB_W-1:0] RANK_4 = 64'h00000000FF000000;
   localparam logic [BB_W-1:0] RANK_5 = 64'h000000FF00000000;
   localparam logic [BB_W-1:0] RANK_6 = 64'h0000FF0000000000;
   localparam logic [BB_W-1:0] RANK_7 = 64'h00FF000000000000;
   localparam logic [BB_W-1:0] RANK_8 = 64'hFF00000000000000;

   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_EMIT_SINGLE = 2'd1;
   localparam logic [1:0] ST_EMIT_DOUBLE = 2'd2;
   localparam logic [1:0] ST_DONE        = 2'd3;

   // Rank index 0..7 (rank 1..rank 8) to its 64-bit mask.
   function automatic logic [BB_W-1:0] rank_mask(input logic [2:0] r);
      case (r)
         3'd0:    return RANK_1;
         3'd1:    return RANK_2;
         3'd2:    return RANK_3;
         3'd3:    return RANK_4;
         3'd4:    return RANK_5;
         3'd5:    return RANK_6;
         3'd6:    return RANK_7;
         default: return RANK_8;
      endcase
   endfunction

   // One-rank push of every set bit toward the side's promotion rank, onto empty squares.
   function automatic logic [BB_W-1:0] pawn_push(input logic [BB_W-1:0] bb,
                                                 input logic [BB_W-1:0] empty_sq,
                                                 input logic            side);
      if (side == SIDE_WHITE)
         return (bb << 8) & empty_sq;
      else
         return (bb >> 8) & empty_sq;
   endfunction

endpackage

// File: rtl/bitboard_lsb_index.sv
// Combinational lowest-set-bit index of a 64-bit bitboard, plus a nonzero flag.
module bitboard_lsb_index (
   input  logic [63:0] bb,
   output logic [5:0]  idx,
   output logic        nonzero
);

   always_comb begin
      idx = '0;
      for (int i = 63; i >= 0; i--) begin
         if (bb[i]) idx = 6'(i);
      end
   end

   assign nonzero = |bb;

endmodule

// File: rtl/pawn_push_move_emitter.sv
// Expands single and double pawn push target maps into a valid/ready stream of
// (from, to) moves: singles ascending, then doubles ascending.
module pawn_push_move_emitter
   import chess_pkg::*;
#(
   parameter int unsigned SQ_W  = SQ_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             side,
   input  logic [63:0]      occupied,
   input  logic [63:0]      pawns,
   output logic             move_valid,
   input  logic             move_ready,
   output logic [SQ_W-1:0]  move_from,
   output logic [SQ_W-1:0]  move_to,
   output logic             move_double,
   output logic             move_promo,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] move_count
);

   logic [1:0]      state;
   logic [1:0]      state_nx;
   logic            side_q;
   logic [63:0]     single_map;
   logic [63:0]     double_map;
   logic [63:0]     start_single;
   logic [63:0]     start_double;
   logic [63:0]     active_map;
   logic [63:0]     active_cleared;
   logic [63:0]     active_lsb_bit;
   logic [63:0]     promo_rank;
   logic [5:0]      lsb_idx;
   logic            lsb_nz;
   logic            in_emit;
   logic            beat;
   logic [SQ_W-1:0] step;

   // Target maps computed from the inputs in the start cycle.
   always_comb begin
      start_single = pawn_push(pawns, ~occupied, side);
      start_double = pawn_push(start_single, ~occupied, side)
                     & ((side == SIDE_BLACK) ? rank_mask(3'd4) : rank_mask(3'd3));
   end

   assign in_emit    = (state == ST_EMIT_SINGLE) || (state == ST_EMIT_DOUBLE);
   assign active_map = (state == ST_EMIT_DOUBLE) ? double_map : single_map;

   bitboard_lsb_index u_lsb (
      .bb      (active_map),
      .idx     (lsb_idx),
      .nonzero (lsb_nz)
   );

   assign active_cleared = active_map & (active_map - 64'd1);
   assign active_lsb_bit = active_map & (~active_map + 64'd1);
   assign promo_rank     = (side_q == SIDE_BLACK) ? rank_mask(3'd0) : rank_mask(3'd7);

   // Move presentation; everything is forced to zero when no move is offered.
   always_comb begin
      move_valid  = in_emit & lsb_nz;
      move_to     = '0;
      move_from   = '0;
      move_double = 1'b0;
      move_promo  = 1'b0;
      step        = SQ_W'(8);
      if (move_valid) begin
         move_to     = SQ_W'(lsb_idx);
         move_double = (state == ST_EMIT_DOUBLE);
         move_promo  = ~move_double & (|(active_lsb_bit & promo_rank));
         step        = move_double ? SQ_W'(16) : SQ_W'(8);
         move_from   = (side_q == SIDE_BLACK) ? (move_to + step) : (move_to - step);
      end
   end

   assign beat = move_valid & move_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next state: each emit phase advances on the cycle it finds its map empty.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:        if (start) state_nx = ST_EMIT_SINGLE;
         ST_EMIT_SINGLE: if (single_map == 64'd0) state_nx = ST_EMIT_DOUBLE;
         ST_EMIT_DOUBLE: if (double_map == 64'd0) state_nx = ST_DONE;
         ST_DONE:        state_nx = ST_IDLE;
         default:        state_nx = ST_IDLE;
      endcase
   end

   // Maps, side, counter and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         side_q     <= SIDE_WHITE;
         single_map <= '0;
         double_map <= '0;
         move_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_nx == ST_EMIT_SINGLE) || (state_nx == ST_EMIT_DOUBLE);
         done <= (state_nx == ST_DONE);
         if ((state == ST_IDLE) && start) begin
            side_q     <= side;
            single_map <= start_single;
            double_map <= start_double;
            move_count <= '0;
         end else if (beat) begin
            if (state == ST_EMIT_DOUBLE) double_map <= active_cleared;
            else                         single_map <= active_cleared;
            move_count <= move_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pawn_push_move_emitter.sv
// Directed bench for pawn_push_move_emitter with a square-by-square push model.
module tb_pawn_push_move_emitter;

   typedef struct packed {
      logic [5:0] from;
      logic [5:0] to;
      logic       dbl;
      logic       promo;
   } mv_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        side;
   logic [63:0] occupied;
   logic [63:0] pawns;
   logic        move_valid;
   logic        move_ready;
   logic [5:0]  move_from;
   logic [5:0]  move_to;
   logic        move_double;
   logic        move_promo;
   logic        busy;
   logic        done;
   logic [4:0]  move_count;

   int  n_checks = 0;
   int  n_errors = 0;
   mv_t exp_q[$];
   mv_t got_q[$];
   mv_t ref_q[$];
   int  exp_count = 0;
   bit  chk_en = 0;
   int  ready_mode = 0;
   bit  hold = 0;
   mv_t held;
   mv_t act;
   int  lat;

   pawn_push_move_emitter dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .side        (side),
      .occupied    (occupied),
      .pawns       (pawns),
      .move_valid  (move_valid),
      .move_ready  (move_ready),
      .move_from   (move_from),
      .move_to     (move_to),
      .move_double (move_double),
      .move_promo  (move_promo),
      .busy        (busy),
      .done        (done),
      .move_count  (move_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic chk_eq(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_checks++;
      if (a !== e) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", nm, a, e);
      end
   endtask

   function automatic mv_t mk(input int f, input int t, input bit d, input bit p);
      mv_t m;
      m.from  = 6'(f);
      m.to    = 6'(t);
      m.dbl   = d;
      m.promo = p;
      return m;
   endfunction

   // Expected move list from the push rules, walking destination squares in order.
   function automatic void build(input logic s, input logic [63:0] occ, input logic [63:0] pw);
      int src;
      int mid;
      exp_q.delete();
      for (int t = 0; t < 64; t++) begin
         src = s ? t + 8 : t - 8;
         if (src >= 0 && src < 64 && pw[src] && !occ[t])
            exp_q.push_back(mk(src, t, 1'b0, s ? (t < 8) : (t >= 56)));
      end
      for (int t = 0; t < 64; t++) begin
         src = s ? t + 16 : t - 16;
         mid = s ? t + 8 : t - 8;
         if ((!s && t >= 24 && t <= 31) || (s && t >= 32 && t <= 39))
            if (pw[src] && !occ[mid] && !occ[t])
               exp_q.push_back(mk(src, t, 1'b1, 1'b0));
      end
   endfunction

   // Ready driver: 0 = always, 1 = random, 2 = every fourth cycle.
   initial begin
      int cyc;
      cyc = 0;
      move_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (ready_mode)
            0:       move_ready = 1'b1;
            1:       move_ready = 1'($urandom_range(0, 1));
            default: move_ready = ((cyc % 4) == 0);
         endcase
      end
   end

   // Per-cycle compare against the model queue.
   always @(negedge clk) begin
      if (chk_en) begin
         chk_eq("move_count", 64'(move_count), 64'(exp_count));
         if (move_valid) begin
            act = mk(int'(move_from), int'(move_to), move_double, move_promo);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL spurious_move: actual %0d->%0d required no move", move_from, move_to);
            end else begin
               chk_eq("move", 64'(act), 64'(exp_q[0]));
               if (hold) chk_eq("move_stable", 64'(act), 64'(held));
               if (move_ready) begin
                  got_q.push_back(act);
                  void'(exp_q.pop_front());
                  exp_count++;
                  hold = 0;
               end else begin
                  hold = 1;
                  held = act;
               end
            end
         end else if (hold) begin
            n_checks++;
            n_errors++;
            $display("FAIL valid_dropped: actual valid 0 required 1");
            hold = 0;
         end
      end
   end

   task automatic run(input logic s, input logic [63:0] occ, input logic [63:0] pw,
                      input int rmode, input bit inject, output int latency);
      bit seen;
      ready_mode = rmode;
      @(posedge clk);
      #1;
      side = s; occupied = occ; pawns = pw; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      build(s, occ, pw);
      exp_count = 0;
      got_q.delete();
      hold = 0;
      chk_en = 1;
      latency = 1;
      seen = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
         chk_eq("busy", 64'(busy), 64'd1);
         @(posedge clk);
         latency++;
         #1;
         if (inject && latency == 5) begin
            start = 1'b1; pawns = ~pw; occupied = 64'd0; side = ~s;
         end else begin
            start = 1'b0;
         end
      end
      chk_eq("done_seen", 64'(seen), 64'd1);
      chk_eq("done_queue_empty", 64'(exp_q.size()), 64'd0);
      chk_eq("busy_in_done", 64'(busy), 64'd0);
      if (inject) begin
         start = 1'b1; pawns = 64'h0000_0000_00FF_0000; occupied = 64'd0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk_eq("done_pulse", 64'(done), 64'd0);
      chk_eq("idle_after_done", 64'(busy), 64'd0);
      chk_en = 0;
      @(negedge clk);
      chk_eq("still_idle", 64'(busy | move_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; side = 1'b0; occupied = '0; pawns = '0;
      #1 rst = 1'b1;
      #1;
      chk_eq("rst_valid", 64'(move_valid), 64'd0);
      chk_eq("rst_busy", 64'(busy), 64'd0);
      chk_eq("rst_done", 64'(done), 64'd0);
      chk_eq("rst_count", 64'(move_count), 64'd0);
      chk_eq("rst_from_to", 64'({move_from, move_to}), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Model pins.
      build(1'b0, 64'h000000000000FF00, 64'h000000000000FF00);
      chk_eq("model_w_size", 64'(exp_q.size()), 64'd16);
      chk_eq("model_w_first", 64'(exp_q[0]), 64'(mk(8, 16, 0, 0)));
      chk_eq("model_w_dbl", 64'(exp_q[8]), 64'(mk(8, 24, 1, 0)));
      build(1'b1, 64'h00FF000000000000, 64'h00FF000000000000);
      chk_eq("model_b_last", 64'(exp_q[15]), 64'(mk(55, 39, 1, 0)));
      build(1'b0, 64'h0001000000000000, 64'h0001000000000000);
      chk_eq("model_promo", 64'(exp_q[0]), 64'(mk(48, 56, 0, 1)));

      // White full second rank.
      run(1'b0, 64'h000000000000FF00, 64'h000000000000FF00, 0, 0, lat);
      chk_eq("w_latency", 64'(lat), 64'd19);
      chk_eq("w_moves", 64'(got_q.size()), 64'd16);
      chk_eq("w_first", 64'(got_q[0]), 64'(mk(8, 16, 0, 0)));
      chk_eq("w_last", 64'(got_q[15]), 64'(mk(15, 31, 1, 0)));
      chk_eq("w_count", 64'(move_count), 64'd16);
      ref_q = got_q;

      // Black full seventh rank.
      run(1'b1, 64'h00FF000000000000, 64'h00FF000000000000, 0, 0, lat);
      chk_eq("b_latency", 64'(lat), 64'd19);
      chk_eq("b_first", 64'(got_q[0]), 64'(mk(48, 40, 0, 0)));
      chk_eq("b_first_dbl", 64'(got_q[8]), 64'(mk(48, 32, 1, 0)));
      chk_eq("b_count", 64'(move_count), 64'd16);

      // e2 pawn with e4 blocked: single only.
      run(1'b0, (64'd1 << 12) | (64'd1 << 28), 64'd1 << 12, 0, 0, lat);
      chk_eq("e4_latency", 64'(lat), 64'd4);
      chk_eq("e4_moves", 64'(got_q.size()), 64'd1);
      chk_eq("e4_move", 64'(got_q[0]), 64'(mk(12, 20, 0, 0)));

      // e3 blocked: empty run.
      run(1'b0, (64'd1 << 12) | (64'd1 << 20), 64'd1 << 12, 0, 0, lat);
      chk_eq("empty_latency", 64'(lat), 64'd3);
      chk_eq("empty_count", 64'(move_count), 64'd0);

      // a7 promotion under backpressure.
      run(1'b0, 64'd1 << 48, 64'd1 << 48, 2, 0, lat);
      chk_eq("bp_moves", 64'(got_q.size()), 64'd1);
      chk_eq("bp_move", 64'(got_q[0]), 64'(mk(48, 56, 0, 1)));
      chk_eq("bp_count", 64'(move_count), 64'd1);

      // Black b2 promotion.
      run(1'b1, 64'd1 << 9, 64'd1 << 9, 0, 0, lat);
      chk_eq("bpromo_move", 64'(got_q[0]), 64'(mk(9, 1, 0, 1)));

      // Mixed board with random ready.
      run(1'b0, 64'h0000000048A55A00, 64'h0000000000A55A00, 1, 0, lat);
      chk_eq("mixed_count", 64'(move_count), 64'(got_q.size()));

      // Reset after three moves.
      ready_mode = 0;
      @(posedge clk);
      #1;
      side = 1'b0; occupied = 64'h000000000000FF00; pawns = 64'h000000000000FF00; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      build(1'b0, occupied, pawns);
      exp_count = 0; got_q.delete(); hold = 0; chk_en = 1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         #1;
         if (exp_count == 3) break;
      end
      @(posedge clk);
      #1;
      chk_en = 0;
      chk_eq("pre_rst_count", 64'(move_count), 64'd3);
      rst = 1'b1;
      #1;
      chk_eq("midrst_valid", 64'(move_valid), 64'd0);
      chk_eq("midrst_from_to", 64'({move_from, move_to}), 64'd0);
      chk_eq("midrst_busy", 64'(busy), 64'd0);
      chk_eq("midrst_count", 64'(move_count), 64'd0);
      repeat (3) begin
         @(negedge clk);
         chk_eq("midrst_no_done", 64'(done), 64'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_eq("postrst_idle", 64'({done, busy}), 64'd0);
      end

      // Clean restart after reset.
      run(1'b0, 64'h000000000000FF00, 64'h000000000000FF00, 0, 0, lat);
      chk_eq("restart_count", 64'(move_count), 64'd16);
      chk_eq("restart_latency", 64'(lat), 64'd19);

      // Start pulses while busy and in DONE are ignored.
      run(1'b0, 64'h000000000000FF00, 64'h000000000000FF00, 1, 1, lat);
      chk_eq("inject_count", 64'(move_count), 64'd16);
      chk_eq("inject_moves", 64'(got_q.size()), 64'(ref_q.size()));
      for (int i = 0; i < 16; i++) begin
         if (i < got_q.size()) chk_eq("inject_same", 64'(got_q[i]), 64'(ref_q[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
